shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_mult_pkg.sv | 13 +
 rtl/ripple_carry_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared widths and FSM state encoding for the sequential shift-add multiplier.
package shift_add_mult_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module ripple_carry_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one partial product per cycle over WIDTH cycles,
// valid/ready on both the operand and the product side.
module shift_add_multiplier
    import shift_add_mult_pkg::*;
#(
    parameter int unsigned WIDTH = shift_add_mult_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    state_t             state, state_d;
    logic [PROD_W-1:0]  acc, acc_d;
    logic [PROD_W-1:0]  mcand, mcand_d;
    logic [WIDTH-1:0]   mplier, mplier_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [PROD_W-1:0]  product_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               in_ready_d;

    logic [PROD_W-1:0]  sum;
    logic               co_unused;

    // Carry-out is dropped: a WIDTH x WIDTH product always fits in 2*WIDTH bits.
    ripple_carry_adder #(
        .W (PROD_W)
    ) u_adder (
        .x  (acc),
        .y  (mcand),
        .ci (1'b0),
        .s  (sum),
        .co (co_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
            cnt       <= cnt_d;
            product   <= product_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            in_ready  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        mcand_d     = mcand;
        mplier_d    = mplier;
        cnt_d       = cnt;
        product_d   = product;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = PROD_W'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = mplier[0] ? sum : acc;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = CNT_W'(cnt + 1'b1);
                // Final step: capture the completed sum so product is stable throughout DONE.
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the next-state decode.
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
        in_ready_d  = (state_d == IDLE);
    end

endmodule
